// File: rtl/riscv_definitions.sv
// Shared types and constants for the instruction fetch path.
package riscv_definitions;

   typedef logic [31:0] dataBus_u;
   typedef logic [31:0] instruction_u;

   localparam instruction_u INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } instMemState_e;

   // Word-aligned and inside a memory of 'depth' words.
   function automatic logic addr_ok(input dataBus_u addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
   endfunction

endpackage

// File: rtl/inst_ram.sv
// Single-port DEPTH x 32 storage, synchronous read; o_rdata holds until the next read.
module inst_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory with program-load port; fetch latency WAIT_STATES+1 cycles.
// inst_ready low while a fetch is in flight; loads win over fetches and only in IDLE.
module instruction_memory
   import riscv_definitions::*;
#(
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic         inst_req,
   input  dataBus_u     inst_addr,
   output instruction_u inst_data,
   output logic         inst_valid,
   output logic         inst_err,
   output logic         inst_ready,
   input  logic         load_en,
   input  logic [31:0]  load_addr,
   input  logic [31:0]  load_data,
   output logic         load_ack
);

   localparam int          AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int          CNT_INIT_I = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
   localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];

   instMemState_e  r_state;
   logic [3:0]     r_cnt;
   logic [AW-1:0]  r_idx;
   logic           r_ok;
   logic           r_valid;
   logic           r_err;
   logic           r_nop;

   logic           w_ready;
   logic           w_load_grant;
   logic           w_load_ok;
   logic           w_req_ok;
   logic           w_accept;
   logic           w_enter_resp;
   logic           w_resp_ok;
   logic [AW-1:0]  w_ram_addr;
   logic [31:0]    w_rdata;

   assign w_ready      = (r_state == IDLE) || ((r_state == RESP) && (WAIT_STATES == 0));
   assign w_load_grant = clk_en && !rst && load_en && (r_state == IDLE);
   assign w_load_ok    = addr_ok(load_addr, MEM_DEPTH);
   assign w_req_ok     = addr_ok(inst_addr, MEM_DEPTH);
   assign w_accept     = clk_en && !rst && inst_req && w_ready && !w_load_grant;

   // The RAM is only read on the edge that enters RESP, so its output register
   // doubles as the held response word.
   assign w_enter_resp = clk_en && !rst &&
                         ((w_accept && (WAIT_STATES == 0)) ||
                          ((r_state == WAIT) && (r_cnt == 4'd0)));
   assign w_resp_ok    = (r_state == WAIT) ? r_ok : w_req_ok;

   always_comb begin
      w_ram_addr = inst_addr[AW+1:2];
      if (w_load_grant) begin
         w_ram_addr = load_addr[AW+1:2];
      end else if (r_state == WAIT) begin
         w_ram_addr = r_idx;
      end
   end

   inst_ram #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_load_grant && w_load_ok),
      .i_re    (w_enter_resp && w_resp_ok),
      .i_addr  (w_ram_addr),
      .i_wdata (load_data),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_ok    <= 1'b0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_nop   <= 1'b1;
      end else if (clk_en) begin
         case (r_state)
            IDLE, RESP: begin
               if (w_accept) begin
                  r_idx <= inst_addr[AW+1:2];
                  r_ok  <= w_req_ok;
                  if (WAIT_STATES == 0) begin
                     r_state <= RESP;
                     r_valid <= 1'b1;
                     r_err   <= !w_req_ok;
                     r_nop   <= !w_req_ok;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_INIT;
                     r_valid <= 1'b0;
                     r_err   <= 1'b0;
                  end
               end else begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= RESP;
                  r_valid <= 1'b1;
                  r_err   <= !r_ok;
                  r_nop   <= !r_ok;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign inst_data  = r_nop ? INST_NOP : w_rdata;
   assign inst_valid = r_valid;
   assign inst_err   = r_err;
   assign inst_ready = w_ready;
   assign load_ack   = w_load_grant;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench: u1 runs with one wait state, u0 with none; both share load/reset/enable.
module tb_instruction_memory;

   localparam int DEPTH = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] W0  = 32'h0050_0093;
   localparam logic [31:0] W1  = 32'h00A0_0113;
   localparam logic [31:0] W2  = 32'h00F0_0193;
   localparam logic [31:0] W3  = 32'h1111_1093;

   logic        clk = 1'b0;
   logic        rst, clk_en, load_en;
   logic [31:0] load_addr, load_data;
   logic        req1, req0;
   logic [31:0] addr1, addr0;
   logic [31:0] data1, data0;
   logic        valid1, valid0, err1, err0, ready1, ready0, ack1, ack0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   instruction_memory #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u1 (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .inst_req(req1), .inst_addr(addr1), .inst_data(data1),
      .inst_valid(valid1), .inst_err(err1), .inst_ready(ready1),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_ack(ack1)
   );

   instruction_memory #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .inst_req(req0), .inst_addr(addr0), .inst_data(data0),
      .inst_valid(valid0), .inst_err(err0), .inst_ready(ready0),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_ack(ack0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      req1 = 1'b0; req0 = 1'b0; addr1 = '0; addr0 = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid1", valid1, 0);
      check("rst_err1",   err1,   0);
      check("rst_data1",  data1,  NOP);
      check("rst_ready1", ready1, 1);
      check("rst_data0",  data0,  NOP);
      check("rst_valid0", valid0, 0);

      // Program load of three words into both instances
      load_en = 1'b1; load_addr = 32'h0; load_data = W0;
      #1;
      check("load_ack1", ack1, 1);
      check("load_ack0", ack0, 1);
      tick();
      load_addr = 32'h4; load_data = W1;
      tick();
      load_addr = 32'h8; load_data = W2;
      tick();
      load_en = 1'b0;
      #1;
      check("load_ack_idle", ack1, 0);

      // One wait state: valid on the second edge after acceptance
      req1 = 1'b1; addr1 = 32'h0;
      tick();
      req1 = 1'b0;
      check("ws1_wait_valid", valid1, 0);
      check("ws1_wait_ready", ready1, 0);
      tick();
      check("ws1_valid", valid1, 1);
      check("ws1_data",  data1,  W0);
      check("ws1_err",   err1,   0);
      tick();
      check("ws1_pulse_end", valid1, 0);
      check("ws1_data_hold", data1,  W0);

      // Zero wait states, back-to-back fetches
      req0 = 1'b1; addr0 = 32'h0;
      tick();
      check("b2b_v0", valid0, 1);
      check("b2b_d0", data0,  W0);
      check("b2b_rdy", ready0, 1);
      addr0 = 32'h4;
      tick();
      check("b2b_v1", valid0, 1);
      check("b2b_d1", data0,  W1);
      addr0 = 32'h8;
      tick();
      check("b2b_v2", valid0, 1);
      check("b2b_d2", data0,  W2);
      req0 = 1'b0;
      tick();
      check("b2b_end",  valid0, 0);
      check("b2b_hold", data0,  W2);

      // Misaligned and out-of-range fetches
      req1 = 1'b1; addr1 = 32'h6;
      tick();
      req1 = 1'b0;
      tick();
      check("mis_valid", valid1, 1);
      check("mis_err",   err1,   1);
      check("mis_data",  data1,  NOP);
      tick();
      check("mis_err_clr", err1, 0);
      req1 = 1'b1; addr1 = 32'(4 * DEPTH);
      tick();
      req1 = 1'b0;
      tick();
      check("oor_valid", valid1, 1);
      check("oor_err",   err1,   1);
      check("oor_data",  data1,  NOP);
      tick();

      // Load and fetch together: load wins, fetch taken next cycle
      load_en = 1'b1; load_addr = 32'hC; load_data = W3;
      req1 = 1'b1; addr1 = 32'hC;
      #1;
      check("pri_ack", ack1, 1);
      tick();
      load_en = 1'b0;
      check("pri_not_accepted", ready1, 1);
      tick();
      req1 = 1'b0;
      check("pri_accepted", ready1, 0);
      tick();
      check("pri_valid", valid1, 1);
      check("pri_data",  data1,  W3);
      tick();

      // Misaligned load is acknowledged but leaves word 0 untouched
      load_en = 1'b1; load_addr = 32'h2; load_data = 32'hDEAD_BEEF;
      #1;
      check("misload_ack", ack1, 1);
      tick();
      load_en = 1'b0;
      req1 = 1'b1; addr1 = 32'h0;
      tick();
      req1 = 1'b0;
      tick();
      check("misload_data", data1, W0);
      tick();

      // Freeze for three cycles in WAIT; address change ignored
      req1 = 1'b1; addr1 = 32'h4;
      tick();
      req1 = 1'b0; addr1 = 32'h8; clk_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_wait_valid", valid1, 0);
      end
      clk_en = 1'b1;
      tick();
      check("frz_valid", valid1, 1);
      check("frz_data",  data1,  W1);
      clk_en = 1'b0;
      tick();
      check("frz_resp_hold", valid1, 1);
      clk_en = 1'b1;
      tick();
      check("frz_resp_end", valid1, 0);

      // Reset during WAIT discards the fetch, memory survives
      req1 = 1'b1; addr1 = 32'h8;
      tick();
      req1 = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstw_valid", valid1, 0);
      check("rstw_data",  data1,  NOP);
      check("rstw_ready", ready1, 1);
      tick();
      check("rstw_no_resp", valid1, 0);
      req1 = 1'b1; addr1 = 32'hC;
      tick();
      req1 = 1'b0;
      tick();
      check("rstw_mem_valid", valid1, 1);
      check("rstw_mem_data",  data1,  W3);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, meaning depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clk_en  input  1  clock enable; low freezes all state.
REQ-006 SHALL have port inst_req  input  1  fetch request.
REQ-007 SHALL have port inst_addr  input  32 (dataBus_u)  fetch byte address.
REQ-008 SHALL have port inst_data  output  32 (instruction_u)  fetched instruction.
REQ-009 SHALL have port inst_valid  output  1  inst_data valid, one-cycle pulse per response.
REQ-010 SHALL have port inst_err  output  1  response error (misaligned or out-of-range), qualified by inst_valid.
REQ-011 SHALL have port inst_ready  output  1  request acceptable this cycle.
REQ-012 SHALL have port load_en  input  1  program-load write request.
REQ-013 SHALL have port load_addr  input  32  load byte address.
REQ-014 SHALL have port load_data  input  32  load word.
REQ-015 SHALL have port load_ack  output  1  load write performed this edge (combinational).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; all transitions and writes only on rising clk with clk_en=1.
REQ-017 SHALL assert inst_ready in IDLE, and in RESP when WAIT_STATES=0; deassert otherwise.
REQ-018 SHALL accept a fetch when inst_req=1, inst_ready=1, and no load is granted that cycle; it captures inst_addr at acceptance and ignores later changes.
REQ-019 SHALL, on acceptance, enter WAIT with counter=WAIT_STATES-1 when WAIT_STATES>0, or enter RESP when WAIT_STATES=0.
REQ-020 SHALL decrement the counter in WAIT and enter RESP the edge after the counter reaches 0; latency is WAIT_STATES+1 cycles from the accepting edge to inst_valid.
REQ-021 SHALL, in RESP, assert inst_valid for exactly one cycle; the next state is IDLE, or RESP when WAIT_STATES=0 and a new request is accepted (back-to-back, one word/cycle).
REQ-022 SHALL return mem[addr[31:2]] when addr[1:0]=0 and addr[31:2] < MEM_DEPTH; otherwise it returns inst_data=0x00000013 (NOP) with inst_err=1, using the same latency.
REQ-023 SHALL hold inst_data stable after a response until the next response; inst_err SHALL be 0 whenever inst_valid=0.
REQ-024 SHALL grant a load only in IDLE; load has priority over inst_req in the same cycle; load_ack=1 in the granting cycle.
REQ-025 SHALL write load_data to mem[load_addr[31:2]] on a granted load; a misaligned or out-of-range load is acknowledged and discarded.
REQ-026 SHALL make a load followed by a fetch of the same address return the new word.
REQ-027 SHALL, with clk_en=0, hold state, counter, and outputs; inst_valid stays asserted if frozen in RESP; load_ack=0.

Reset
REQ-028 SHALL, on rst=1 at a rising edge regardless of clk_en, go to IDLE, clear the counter, set inst_valid=0, inst_err=0, and inst_data=0x00000013.
REQ-029 SHALL discard an in-flight fetch on reset mid-operation; no response is produced for it.
REQ-030 SHALL not reset memory contents.

Structure
REQ-031 SHALL place the FSM state enum (instMemState_e) and the constant INST_NOP=0x00000013 in riscv_definitions.
REQ-032 SHALL isolate storage in sub-module inst_ram: single-port, synchronous-read, one write port, MEM_DEPTH x 32.

Verification
REQ-033 SHALL test load of 0x00500093 at 0x0 (load_ack=1), then fetch 0x0 with WAIT_STATES=1 -> inst_valid exactly 2 cycles after acceptance, inst_data=0x00500093, inst_err=0.
REQ-034 SHALL test WAIT_STATES=0 with fetches 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive valid pulses carrying the loaded words in order.
REQ-035 SHALL test fetch 0x6 and fetch 4*MEM_DEPTH -> inst_valid with inst_err=1, inst_data=0x00000013.
REQ-036 SHALL test load_en and inst_req asserted together in IDLE -> load_ack=1, fetch not accepted, fetch accepted the next cycle and returns the new word.
REQ-037 SHALL test clk_en=0 for 3 cycles during WAIT -> response delayed by exactly 3 cycles; inst_addr changed during WAIT has no effect.
REQ-038 SHALL test rst=1 during WAIT -> IDLE next cycle, no inst_valid, inst_data=0x00000013, previously loaded memory still readable.
